// File: rtl/ccff_prog_pkg.sv
// Shared types and CRC-8 helper for the CCFF chain programmer.
// CRC-8 is x^8+x^2+x+1, init 0, one bit per step, MSB-first register form.
package ccff_prog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } prog_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_prog_crc8.sv
// Serial CRC-8 register: synchronous clear, one bit folded per enabled cycle.
module ccff_prog_crc8
    import ccff_prog_pkg::*;
(
    input  logic       prog_clk,
    input  logic       prog_reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ccff_chain_programmer.sv
// Serialises bitstream words onto a CCFF chain, then loops the tail back to the head
// for one full rotation and compares CRC-8 of the loaded and read-back streams.
module ccff_chain_programmer
    import ccff_prog_pkg::*;
#(
    parameter int  CHAIN_LEN = 4,
    parameter int  WORD_W    = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic [0:WORD_W-1] bs_data,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int                 REM_W          = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LOAD_END   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]   CNT_VERIFY_END = CNT_W'(CHAIN_LEN - 1);
    localparam logic [REM_W-1:0]   REM_FULL       = REM_W'(WORD_W);
    localparam logic [REM_W-1:0]   REM_ONE        = REM_W'(1);

    prog_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;     // bits still held, including the one on the head
    logic [0:WORD_W-1] word_q, word_d, word_next;
    logic              head_q, head_d;
    logic              loop_q, loop_d;
    logic              ready_d, en_d, busy_d, done_d, pass_d;
    logic              crc_clr, tx_en, tx_din, rx_en;
    logic [7:0]        crc_tx, crc_rx;

    // During VERIFY the tail is routed straight back so the chain rotates exactly once.
    assign ccff_head = loop_q ? ccff_tail : head_q;
    assign word_next = word_q << 1;

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        word_d  = word_q;
        head_d  = head_q;
        loop_d  = loop_q;
        ready_d = 1'b0;
        en_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        crc_clr = 1'b0;
        tx_en   = 1'b0;
        tx_din  = 1'b0;
        rx_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    rem_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    pass_d  = 1'b0;
                    crc_clr = 1'b1;
                end
            end
            LOAD: begin
                if (chain_clk_en) begin
                    if (cnt_q == CNT_LOAD_END) begin
                        state_d = VERIFY;
                        cnt_d   = '0;
                        rem_d   = '0;
                        head_d  = 1'b0;
                        loop_d  = 1'b1;
                        en_d    = 1'b1;
                    end else if (rem_q != REM_ONE) begin
                        rem_d  = rem_q - REM_ONE;
                        word_d = word_next;
                        head_d = word_next[0];
                        en_d   = 1'b1;
                        cnt_d  = cnt_q + CNT_ONE;
                        tx_en  = 1'b1;
                        tx_din = word_next[0];
                    end else begin
                        rem_d   = '0;
                        ready_d = 1'b1;
                    end
                end else if (bs_valid && bs_ready) begin
                    word_d = bs_data;
                    rem_d  = REM_FULL;
                    head_d = bs_data[0];
                    en_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                    tx_en  = 1'b1;
                    tx_din = bs_data[0];
                end else begin
                    ready_d = bs_ready;
                end
            end
            VERIFY: begin
                rx_en = 1'b1;
                if (cnt_q == CNT_VERIFY_END) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    loop_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    en_d  = 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (crc_tx == crc_rx);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            word_q       <= '0;
            head_q       <= 1'b0;
            loop_q       <= 1'b0;
            bs_ready     <= 1'b0;
            chain_clk_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            word_q       <= word_d;
            head_q       <= head_d;
            loop_q       <= loop_d;
            bs_ready     <= ready_d;
            chain_clk_en <= en_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
        end
    end

    ccff_prog_crc8 u_crc_tx (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clr          (crc_clr),
        .en           (tx_en),
        .din          (tx_din),
        .crc          (crc_tx)
    );

    ccff_prog_crc8 u_crc_rx (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clr          (crc_clr),
        .en           (rx_en),
        .din          (ccff_tail),
        .crc          (crc_rx)
    );

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Bench for ccff_chain_programmer: three instances (chain lengths 4, 20, 1) each driving
// a behavioural shift-register chain; runs are checked against a stream-level model.
module tb_ccff_chain_programmer;

    localparam int L0 = 4;
    localparam int L1 = 20;
    localparam int L2 = 1;

    logic       clk;
    logic       rst_n;
    logic       start_s    [3];
    logic       bs_valid_s [3];
    logic [0:7] bs_data_s  [3];
    logic       stuck_s    [3];
    wire        bs_ready_w [3];
    wire        head_w     [3];
    wire        en_w       [3];
    wire        tail_w     [3];
    wire        busy_w     [3];
    wire        done_w     [3];
    wire        pass_w     [3];
    logic [63:0] chain_m   [3];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LEN = (g == 0) ? L0 : (g == 1) ? L1 : L2;
        assign tail_w[g] = stuck_s[g] ? 1'b0 : chain_m[g][LEN-1];
        ccff_chain_programmer #(.CHAIN_LEN(LEN), .WORD_W(8)) dut (
            .prog_clk     (clk),
            .prog_reset_n (rst_n),
            .start        (start_s[g]),
            .bs_valid     (bs_valid_s[g]),
            .bs_ready     (bs_ready_w[g]),
            .bs_data      (bs_data_s[g]),
            .ccff_head    (head_w[g]),
            .chain_clk_en (en_w[g]),
            .ccff_tail    (tail_w[g]),
            .busy         (busy_w[g]),
            .done         (done_w[g]),
            .pass         (pass_w[g])
        );
    end

    // External chain: c0 takes the head, tail is the last stage; not reset by the block.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (en_w[k]) chain_m[k] <= {chain_m[k][62:0], head_w[k]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int g);
        case (g)
            0:       return L0;
            1:       return L1;
            default: return L2;
        endcase
    endfunction

    function automatic logic [5:0] outs(input int g);
        return {bs_ready_w[g], head_w[g], en_w[g], busy_w[g], done_w[g], pass_w[g]};
    endfunction

    // CRC as the remainder of message * x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input bit q[$]);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < q.size() + 8; i++) begin
            r = {r[7:0], (i < q.size()) ? q[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic run(input int g, input int gap_fix, input int gap_max, input bit stuck,
                       input bit fix_word, input logic [0:7] word0, input bit poke,
                       input int rst_cyc);
        int          len, nw, cyc, gap, stalls, widx, done_cyc, done_cnt, after;
        bit          ld[$];
        bit          rb[$];
        bit          cap[$];
        logic [0:7]  words[$];
        logic [63:0] exp_ld, exp_rb, got_ld, got_rb, exp_chain, msk;
        logic        got_pass;
        len = len_of(g);
        nw  = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            logic [0:7] d;
            d = (w == 0 && fix_word) ? word0 : 8'($urandom);
            words.push_back(d);
            for (int i = 0; i < 8; i++)
                if (ld.size() < len) ld.push_back(d[i]);
        end
        for (int i = 0; i < len; i++) rb.push_back(stuck ? 1'b0 : ld[i]);
        stuck_s[g] = stuck;
        stalls   = 0;
        widx     = 0;
        done_cyc = -1;
        done_cnt = 0;
        after    = 0;
        gap      = 0;
        got_pass = 1'b0;
        @(negedge clk);
        start_s[g] = 1'b1;
        cyc = 0;
        while (cyc < 400 && after < 3) begin
            @(negedge clk);
            cyc++;
            start_s[g] = poke && (cyc == 3);
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid_run_outputs", outs(g), 0);
                bs_valid_s[g] = 1'b0;
                start_s[g]    = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc == 1) check("start_busy_ready", {busy_w[g], bs_ready_w[g]}, 2'b11);
            if (en_w[g]) cap.push_back(head_w[g]);
            if (done_w[g]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    got_pass = pass_w[g];
                end
            end
            if (done_cyc >= 0) after++;
            bs_valid_s[g] = 1'b0;
            if (bs_ready_w[g] && widx < nw) begin
                if (gap > 0) begin
                    gap--;
                    stalls++;
                    check("stall_clk_en", en_w[g], 0);
                end else begin
                    bs_valid_s[g] = 1'b1;
                    bs_data_s[g]  = words[widx];
                    widx++;
                    gap = (gap_fix >= 0) ? gap_fix : $urandom_range(gap_max, 0);
                end
            end
        end
        exp_ld = '0; exp_rb = '0; got_ld = '0; got_rb = '0; exp_chain = '0; msk = '0;
        for (int i = 0; i < len; i++) begin
            exp_ld[i] = ld[i];
            exp_rb[i] = rb[i];
            if (i < cap.size())       got_ld[i] = cap[i];
            if (i + len < cap.size()) got_rb[i] = cap[i + len];
            exp_chain[len - 1 - i] = rb[i];
            msk[i] = 1'b1;
        end
        check("done_seen", done_cyc >= 0, 1);
        check("done_cycle", done_cyc, nw + 2 * len + 2 + stalls);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy_w[g], 0);
        check("enabled_edges", cap.size(), 2 * len);
        check("load_bits", got_ld, exp_ld);
        check("readback_bits", got_rb, exp_rb);
        check("chain_contents", chain_m[g] & msk, exp_chain);
        check("pass", got_pass, ref_crc(ld) == ref_crc(rb));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_s[k]    = 1'b0;
            bs_valid_s[k] = 1'b0;
            bs_data_s[k]  = '0;
            stuck_s[k]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check("reset_outputs", outs(k), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 0, 1'b0, 1'b1, 8'b1011_0000, 1'b0, 0);
        run(0, 0, 0, 1'b1, 1'b1, 8'b1011_0000, 1'b0, 0);
        run(1, 5, 0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        run(0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        run(0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1 + L0 + 3);
        run(0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        run(2, 0, 0, 1'b0, 1'b1, 8'b1000_0000, 1'b0, 0);
        for (int r = 0; r < 9; r++)
            run(r % 3, -1, 3, 1'b0, 1'b0, 8'h00, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
